// File: rtl/clock_disp_pkg.sv
// ---------------------------------------------------------------------------
// clock_disp_pkg
// Shared constants for the time-digit display path: digit count, slot
// indices (scan order of the six BCD digits), and the active-low 7-segment
// codes in {g,f,e,d,c,b,a} order.
// ---------------------------------------------------------------------------
package clock_disp_pkg;

    localparam int NUM_DIGITS = 6;

    // Scan order: units before tens, seconds first.
    typedef enum logic [2:0] {
        SLOT_SEC1  = 3'd0,
        SLOT_SEC2  = 3'd1,
        SLOT_MIN1  = 3'd2,
        SLOT_MIN2  = 3'd3,
        SLOT_HOUR1 = 3'd4,
        SLOT_HOUR2 = 3'd5
    } slot_e;

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    // Index = BCD value. Codes 10..15 are not valid BCD and show a dash.
    localparam logic [6:0] SEG_CODE [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        SEG_DASH,    // 10
        SEG_DASH,    // 11
        SEG_DASH,    // 12
        SEG_DASH,    // 13
        SEG_DASH,    // 14
        SEG_DASH     // 15
    };

endpackage : clock_disp_pkg

// File: rtl/bcd_to_seg7.sv
// ---------------------------------------------------------------------------
// bcd_to_seg7
// Combinational BCD to common-anode 7-segment decoder.
// Ports:
//   bcd_i  [3:0]  BCD digit (10..15 decode to a dash)
//   seg_o  [6:0]  segments {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module bcd_to_seg7
    import clock_disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_CODE[bcd_i];

endmodule : bcd_to_seg7

// File: rtl/bcd_scan_display.sv
// ---------------------------------------------------------------------------
// bcd_scan_display
// Drives a 6-digit multiplexed common-anode 7-segment display from the BCD
// time-digit bus. All six digits are snapshotted at the start of each frame
// so a frame never shows a mix of old and new time. Each digit slot starts
// with BLANK_CYC dark cycles to suppress ghosting. The hour-tens digit is
// blanked when zero, and a colon (dp on slots 2 and 4) toggles on every
// change of the live seconds-units input.
// Ports:
//   clk               system clock
//   rst               asynchronous reset, active-high
//   sec_1 .. hour_2   BCD digits (units/tens of sec, min, hour)
//   an     [5:0]      digit enables, active-low, at most one low
//   seg    [6:0]      segments {g,f,e,d,c,b,a}, active-low
//   dp                decimal point, active-low
// Outputs are registered: the value in cycle t+1 reflects scan state in t.
// ---------------------------------------------------------------------------
module bcd_scan_display
    import clock_disp_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sec_1,
    input  logic [3:0] sec_2,
    input  logic [3:0] min_1,
    input  logic [3:0] min_2,
    input  logic [3:0] hour_1,
    input  logic [3:0] hour_2,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0]      cnt_q,  cnt_d;
    slot_e                 slot_q, slot_d;
    logic [3:0]            snap_q [NUM_DIGITS];
    logic [3:0]            snap_d [NUM_DIGITS];
    logic                  colon_q, colon_d;
    logic [3:0]            prev_sec_q;
    logic [NUM_DIGITS-1:0] an_q,  an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q,  dp_d;

    logic       frame_start;
    logic       in_blank;
    logic       lz_blank;
    logic [3:0] cur_digit;
    logic [6:0] cur_seg;

    // -----------------------------------------------------------------------
    // Scan counter and slot sequencing
    // -----------------------------------------------------------------------
    assign frame_start = (slot_q == SLOT_SEC1) && (cnt_q == '0);

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned; that is what keeps latches from appearing.
    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        slot_d = slot_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            slot_d = (slot_q == SLOT_HOUR2) ? SLOT_SEC1 : slot_e'(slot_q + 3'd1);
        end
    end

    // -----------------------------------------------------------------------
    // Frame snapshot: the display only ever reads snap_q.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            snap_d[i] = snap_q[i];
        end
        if (frame_start) begin
            snap_d[SLOT_SEC1]  = sec_1;
            snap_d[SLOT_SEC2]  = sec_2;
            snap_d[SLOT_MIN1]  = min_1;
            snap_d[SLOT_MIN2]  = min_2;
            snap_d[SLOT_HOUR1] = hour_1;
            snap_d[SLOT_HOUR2] = hour_2;
        end
    end

    // -----------------------------------------------------------------------
    // Colon: toggles on any change of the live seconds-units digit, so it
    // tracks the time counter rather than the frame snapshot.
    // -----------------------------------------------------------------------
    always_comb begin
        colon_d = colon_q;
        if (sec_1 != prev_sec_q) begin
            colon_d = ~colon_q;
        end
    end

    // -----------------------------------------------------------------------
    // Digit select and decode
    // -----------------------------------------------------------------------
    always_comb begin
        cur_digit = snap_q[SLOT_SEC1];
        case (slot_q)
            SLOT_SEC1:  cur_digit = snap_q[SLOT_SEC1];
            SLOT_SEC2:  cur_digit = snap_q[SLOT_SEC2];
            SLOT_MIN1:  cur_digit = snap_q[SLOT_MIN1];
            SLOT_MIN2:  cur_digit = snap_q[SLOT_MIN2];
            SLOT_HOUR1: cur_digit = snap_q[SLOT_HOUR1];
            SLOT_HOUR2: cur_digit = snap_q[SLOT_HOUR2];
            default:    cur_digit = snap_q[SLOT_SEC1];
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd_i (cur_digit),
        .seg_o (cur_seg)
    );

    // -----------------------------------------------------------------------
    // Output next-state
    // -----------------------------------------------------------------------
    assign in_blank = (cnt_q < CNT_BLANK);
    assign lz_blank = (slot_q == SLOT_HOUR2) && (snap_q[SLOT_HOUR2] == 4'd0);

    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (!in_blank && !lz_blank) begin
            an_d  = ~(NUM_DIGITS'(1) << slot_q);
            seg_d = cur_seg;
            dp_d  = ~(colon_q && ((slot_q == SLOT_MIN1) || (slot_q == SLOT_HOUR1)));
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    // NOTE: the snapshot is a handful of flops, not a RAM, and it is reset so
    // the display is defined from the very first cycle after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            slot_q     <= SLOT_SEC1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                snap_q[i] <= 4'd0;
            end
            colon_q    <= 1'b0;
            prev_sec_q <= 4'd0;
            an_q       <= '1;
            seg_q      <= SEG_OFF;
            dp_q       <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            slot_q     <= slot_d;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                snap_q[i] <= snap_d[i];
            end
            colon_q    <= colon_d;
            prev_sec_q <= sec_1;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule : bcd_scan_display

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
Consumer end of the BCD time-digit bus produced by the time counter. It samples the six BCD digits (sec, min, hour; units and tens) and drives a 6-digit multiplexed common-anode 7-segment display: one-hot digit-enable scanning, BCD-to-segment decode, and anti-ghost blanking. It also provides hour-tens leading-zero suppression and a colon decimal point that toggles on every seconds change. It sits between the time counter and the board pins.

Parameters:
SCAN_DIV, 50000, clk cycles per digit slot (frame = 6*SCAN_DIV cycles); legal range >= 2
BLANK_CYC, 8, cycles at the start of each slot with all digits off (anti-ghost); legal range 1 <= BLANK_CYC < SCAN_DIV

Ports:
clk  in  1  system clock
rst  in  1  reset. One clock; reset is asynchronous and active-high.
sec_1  in  4  seconds units, BCD
sec_2  in  4  seconds tens, BCD
min_1  in  4  minutes units, BCD
min_2  in  4  minutes tens, BCD
hour_1  in  4  hours units, BCD
hour_2  in  4  hours tens, BCD
an  out  6  digit enables, active-low, one-hot-low; an[k] = slot k
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low

Behaviour:
- Reset (async, rst=1): an=6'b111111, seg=7'b1111111, dp=1. cnt=0, slot=0, snapshot regs=0, colon=0, prev_sec=0.
- cnt counts 0..SCAN_DIV-1 and wraps. On wrap, slot increments 0..5 and wraps from 5 to 0.
- Slot map:
  - 0 = sec_1, 1 = sec_2, 2 = min_1, 3 = min_2, 4 = hour_1, 5 = hour_2.
  - _1 is the units digit, _2 is the tens digit.
- Frame snapshot: all six inputs are captured into snapshot regs in any cycle where slot==0 and cnt==0, including the first cycle after reset release. The display shows only snapshot values, so there is no tearing within a frame. Input changes mid-frame are not shown until the next frame start.
- Outputs are registered. Outputs in cycle t+1 are a function of (slot, cnt, snapshot, colon) in cycle t.
- Within slot k:
  - cnt < BLANK_CYC: an=111111, seg=1111111, dp=1.
  - otherwise: an[k]=0 and all other an bits 1; seg = decode(snapshot[k]).
- Decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any value 10..15 decodes to dash 0111111 (g only lit).
- Leading-zero blank: in slot 5, if snapshot hour_2==0, an stays 111111 and seg=1111111 for the whole slot. Cnt and slot keep advancing normally.
- Colon:
  - prev_sec registers sec_1 every cycle.
  - When sec_1 != prev_sec (live input, not snapshot), colon toggles.
  - dp=0 during the active (non-blank) portion of slots 2 and 4 when colon=1; otherwise dp=1.
  - Multiple sec_1 changes in one frame each toggle colon.
- rst asserted mid-frame: all state returns to reset values immediately (outputs go dark asynchronously). Scanning restarts at slot 0 / cnt 0 with a fresh snapshot.
- Only one an bit may ever be 0. Between slots there are at least BLANK_CYC cycles with an=111111.

Decomposition:
- Shared package clock_disp_pkg holds:
  - NUM_DIGITS=6
  - slot index constants SLOT_SEC1..SLOT_HOUR2
  - segment constants SEG_OFF=7'b1111111 and SEG_DASH=7'b0111111
  - the 16-entry segment code constants
- One combinational sub-module, bcd_to_seg7 (4-bit BCD in, 7-bit active-low segments out, dash for 10..15), instantiated once on the muxed snapshot digit.
- Scan counter, snapshot, colon and output registers live in bcd_scan_display.

Test Plan:
All scenarios use SCAN_DIV=4, BLANK_CYC=1 (frame = 24 cycles).
- Reset and basic scan:
  - Stimulus: inputs hour 12:34:56 (hour_2=1, hour_1=2, min_2=3, min_1=4, sec_2=5, sec_1=6); release rst; sample.
  - Required: during rst an=111111, seg=1111111, dp=1. Each slot shows 1 blank cycle then 3 active cycles.
  - Active cycles: slot0 an=111110 seg=0000010; slot4 an=101111 seg=0100100; slot5 an=011111 seg=1111001.
- Snapshot hold:
  - Stimulus: change min_1 from 4 to 7 in cycle 10 of a frame.
  - Required: slot2 of the current frame still shows seg=0011001. Slot2 of the next frame shows seg=1111000.
- Leading-zero blank:
  - Stimulus: hour_2=0, hour_1=9.
  - Required: slot5 an=111111 and seg=1111111 for all 4 cycles. Slot4 shows an=101111 seg=0010000.
- Colon toggle:
  - Stimulus: sec_1 steps 6 then 7.
  - Required: colon=1, so dp=0 on active cycles of slots 2 and 4 only. A further step 7 then 8 returns dp=1 everywhere.
- Invalid BCD:
  - Stimulus: sec_2=4'hC.
  - Required: slot1 seg=0111111.
- Async reset mid-frame:
  - Stimulus: assert rst at slot 3 cnt 2, with no clock edge.
  - Required: an=111111, seg=1111111, dp=1 immediately. After release, the next active output is slot0 with a fresh snapshot.
